// File: rtl/pipe_store_buffer.sv
// Posted-write store buffer between the CPU MEM stage and slow data memory.
// Queues stores, drains over req/ack, forwards queued data to loads.
module pipe_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_wen,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  output logic [31:0]     cpu_rdata,
  output logic            cpu_stall,
  output logic            mem_wreq,
  output logic [31:0]     mem_waddr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_wack,
  output logic [31:0]     mem_raddr,
  input  logic [31:0]     mem_rdata,
  output logic [PTRW:0]   sb_count,
  output logic            sb_empty
);

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] CNT_TWO  = (PTRW+1)'(2);
  localparam logic [PTRW:0] CNT_ZERO = '0;
  localparam logic [PTRW:0] CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE = (PTRW)'(1);

  sb_entry_t       ent_q [DEPTH];
  logic [PTRW-1:0] head_q;
  logic [PTRW-1:0] tail_q;
  logic [PTRW:0]   count_q;

  logic [PTRW-1:0] young;
  logic            merge_hit;
  logic            push;
  logic            pop;
  logic            full;
  logic            nonempty;

  assign young    = tail_q - PTR_ONE;
  assign full     = (count_q == CNT_FULL);
  assign nonempty = (count_q != CNT_ZERO);

  // The head is visible to memory, so merging needs at least two entries.
  assign merge_hit = cpu_wen
                   & (count_q >= CNT_TWO)
                   & (ent_q[young].addr == cpu_addr[31:2]);

  assign push      = cpu_wen & ~merge_hit & ~full;
  assign pop       = nonempty & mem_wack;
  assign cpu_stall = cpu_wen & ~merge_hit & full;

  assign mem_wreq  = nonempty;
  assign mem_waddr = {ent_q[head_q].addr, 2'b00};
  assign mem_wdata = ent_q[head_q].data;
  assign mem_raddr = cpu_addr;
  assign sb_count  = count_q;
  assign sb_empty  = ~nonempty;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTRW-1:0] idx;
    cpu_rdata = mem_rdata;
    idx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + (PTRW)'(i);
      if (((PTRW+1)'(i) < count_q) &&
          (ent_q[idx].addr == cpu_addr[31:2]))
        cpu_rdata = ent_q[idx].data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q].addr <= cpu_addr[31:2];
        ent_q[tail_q].data <= cpu_wdata;
        tail_q <= tail_q + PTR_ONE;
      end
      if (merge_hit)
        ent_q[young].data <= cpu_wdata;
      if (pop)
        head_q <= head_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_store_buffer.sv
// Directed self-checking bench for pipe_store_buffer.
// One task per scenario; memory writes are logged on ack edges.
module tb_pipe_store_buffer;

  logic        clk;
  logic        rst;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_wreq;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wack;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  logic [31:0] log_a [$];
  logic [31:0] log_d [$];

  pipe_store_buffer #(.DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_wreq(mem_wreq),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wack(mem_wack), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .sb_count(sb_count),
    .sb_empty(sb_empty)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && mem_wreq && mem_wack) begin
      log_a.push_back(mem_waddr);
      log_d.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    cpu_wen   = 1;
    cpu_addr  = a;
    cpu_wdata = d;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL store_stall a=%h got %b want 0",
               a, cpu_stall);
    end
    tick();
    cpu_wen = 0;
  endtask

  task automatic test_reset();
    rst = 0; mem_wack = 1; cpu_wen = 0;
    cpu_addr = 32'h40; cpu_wdata = 0;
    mem_rdata = 32'h1111;
    tick(); tick();
    rst = 1;
    tick();
    checks++;
    if (mem_wreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_wreq got %b want 0", mem_wreq);
    end
    checks++;
    if (sb_empty !== 1'b1 || sb_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_occ got %b/%0d want 1/0",
               sb_empty, sb_count);
    end
    checks++;
    if (cpu_rdata !== 32'h1111) begin
      errors++;
      $display("FAIL rst_rdata got %h want 1111", cpu_rdata);
    end
    checks++;
    if (cpu_stall !== 1'b0 || mem_waddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_misc stall %b waddr %h want 0/0",
               cpu_stall, mem_waddr);
    end
  endtask

  task automatic test_single();
    log_a.delete(); log_d.delete();
    mem_wack = 0;
    store(32'h100, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_wreq !== 1'b1 || mem_waddr !== 32'h100 ||
          mem_wdata !== 32'hAAAA5555 || sb_count !== 3'd1) begin
        errors++;
        $display("FAIL single_hold cyc %0d got %b %h %h %0d want 1 100 aaaa5555 1",
                 i, mem_wreq, mem_waddr, mem_wdata, sb_count);
      end
      tick();
    end
    mem_wack = 1;
    tick();
    mem_wack = 0;
    checks++;
    if (sb_count !== 3'd0 || sb_empty !== 1'b1 ||
        mem_wreq !== 1'b0) begin
      errors++;
      $display("FAIL single_done got %0d %b %b want 0 1 0",
               sb_count, sb_empty, mem_wreq);
    end
    checks++;
    if (log_a.size() != 1 || log_d[0] !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL single_log got n=%0d want 1",
               log_a.size());
    end
  endtask

  task automatic test_fill();
    logic [31:0] ea [5];
    logic [31:0] ed [5];
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    ed = '{32'h100, 32'h104, 32'h108, 32'hCC, 32'h110};
    log_a.delete(); log_d.delete();
    mem_wack = 0;
    store(32'h0, 32'h100);
    store(32'h4, 32'h104);
    store(32'h8, 32'h108);
    store(32'hC, 32'h10C);
    checks++;
    if (sb_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_count got %0d want 4", sb_count);
    end
    // merge into youngest while full is still accepted
    store(32'hC, 32'hCC);
    cpu_wen = 1; cpu_addr = 32'h10; cpu_wdata = 32'h110;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL fill_stall got %b want 1", cpu_stall);
    end
    mem_wack = 1;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL fill_stall_pop got %b want 1", cpu_stall);
    end
    tick();
    mem_wack = 0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || sb_count !== 3'd3) begin
      errors++;
      $display("FAIL fill_after_pop got %b %0d want 0 3",
               cpu_stall, sb_count);
    end
    tick();
    cpu_wen = 0;
    checks++;
    if (sb_count !== 3'd4 || log_a.size() != 1 ||
        log_a[0] !== 32'h0) begin
      errors++;
      $display("FAIL fill_first got cnt %0d n %0d want 4 1",
               sb_count, log_a.size());
    end
    mem_wack = 1;
    for (int i = 0; i < 4; i++) tick();
    mem_wack = 0;
    checks++;
    if (sb_count !== 3'd0 || log_a.size() != 5) begin
      errors++;
      $display("FAIL fill_drain got cnt %0d n %0d want 0 5",
               sb_count, log_a.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
          errors++;
          $display("FAIL fill_order %0d got %h/%h want %h/%h",
                   i, log_a[i], log_d[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_merge();
    log_a.delete(); log_d.delete();
    mem_wack = 0;
    store(32'h20, 32'h1);
    store(32'h24, 32'h2);
    store(32'h24, 32'h3);
    checks++;
    if (sb_count !== 3'd2) begin
      errors++;
      $display("FAIL merge_count got %0d want 2", sb_count);
    end
    mem_wack = 1;
    tick(); tick();
    mem_wack = 0;
    checks++;
    if (log_a.size() != 2) begin
      errors++;
      $display("FAIL merge_n got %0d want 2", log_a.size());
    end else begin
      checks++;
      if (log_a[0] !== 32'h20 || log_d[0] !== 32'h1 ||
          log_a[1] !== 32'h24 || log_d[1] !== 32'h3) begin
        errors++;
        $display("FAIL merge_seq got %h/%h %h/%h want 20/1 24/3",
                 log_a[0], log_d[0], log_a[1], log_d[1]);
      end
    end
    store(32'h50, 32'h9);
    store(32'h50, 32'hA);
    checks++;
    if (sb_count !== 3'd2 || mem_wdata !== 32'h9) begin
      errors++;
      $display("FAIL merge_head got %0d %h want 2 9",
               sb_count, mem_wdata);
    end
    mem_wack = 1;
    tick(); tick();
    mem_wack = 0;
  endtask

  task automatic test_fwd();
    mem_wack = 0;
    mem_rdata = 32'hDEAD;
    store(32'h30, 32'h5);
    store(32'h34, 32'h6);
    store(32'h30, 32'h7);
    cpu_addr = 32'h30;
    #1;
    checks++;
    if (cpu_rdata !== 32'h7 || sb_count !== 3'd3 ||
        mem_raddr !== 32'h30) begin
      errors++;
      $display("FAIL fwd_young got %h cnt %0d raddr %h want 7 3 30",
               cpu_rdata, sb_count, mem_raddr);
    end
    cpu_addr = 32'h38;
    #1;
    checks++;
    if (cpu_rdata !== 32'hDEAD) begin
      errors++;
      $display("FAIL fwd_miss got %h want dead", cpu_rdata);
    end
    cpu_addr = 32'h32;
    #1;
    checks++;
    if (cpu_rdata !== 32'h7) begin
      errors++;
      $display("FAIL fwd_word got %h want 7", cpu_rdata);
    end
    cpu_wen = 1; cpu_addr = 32'h38; cpu_wdata = 32'h99;
    #1;
    checks++;
    if (cpu_rdata !== 32'hDEAD) begin
      errors++;
      $display("FAIL fwd_same_cyc got %h want dead", cpu_rdata);
    end
    cpu_wen = 0;
    mem_wack = 1;
    tick();
    mem_wack = 0;
    cpu_addr = 32'h34;
    #1;
    checks++;
    if (cpu_rdata !== 32'h6 || sb_count !== 3'd2) begin
      errors++;
      $display("FAIL fwd_after_pop got %h %0d want 6 2",
               cpu_rdata, sb_count);
    end
    store(32'h3C, 32'h8);
  endtask

  task automatic test_reset_mid();
    log_a.delete(); log_d.delete();
    mem_wack = 0;
    checks++;
    if (sb_count !== 3'd3 || mem_wreq !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %0d %b want 3 1",
               sb_count, mem_wreq);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (mem_wreq !== 1'b0 || sb_count !== 3'd0 ||
        sb_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got %b %0d %b want 0 0 1",
               mem_wreq, sb_count, sb_empty);
    end
    tick();
    rst = 1;
    mem_wack = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (log_a.size() != 0 || mem_wreq !== 1'b0) begin
      errors++;
      $display("FAIL mid_nowrite got n %0d wreq %b want 0 0",
               log_a.size(), mem_wreq);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_merge();
    test_fwd();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
